// File: rtl/perf_counter_bank_if.sv
// Load/store bus between the rv32 core and the performance counter bank.
// The core drives the master side; the counter bank is the slave.
interface perf_bus_if;
  logic        req;
  logic [31:0] addr;
  logic        rw;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        sel;

  modport master (output req, addr, rw, size, wdata, input rdata, rvalid, sel);
  modport slave  (input req, addr, rw, size, wdata, output rdata, rvalid, sel);
endinterface

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of NUM_CH event counters with enables, sticky overflow, snapshot and irq.
// Optional macro PERFCNT_RD_CLEAR_EN: a live-counter read also zeroes that counter.
module perf_counter_bank #(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  perf_bus_if.slave         bus,
  input  logic [NUM_CH-1:0] inc_i,
  output logic              irq_o
);

  localparam int unsigned WIN_SZ   = 256;
  localparam logic [5:0]  WI_CTRL  = 6'h00;
  localparam logic [5:0]  WI_OVF   = 6'h01;
  localparam logic [5:0]  WI_MASK  = 6'h02;
  localparam logic [5:0]  WI_SNAP  = 6'h03;
  localparam logic [1:0]  GRP_LIVE = 2'b01;
  localparam logic [1:0]  GRP_SNAP = 2'b10;

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  snap_q [NUM_CH];
  logic [CNT_W-1:0]  snap_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              glb_q, glb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              irq_q, irq_d;

  logic [32:0]       addr_ext_c;
  logic [5:0]        wi_c;
  logic              acc_c, wr_c, rd_c;
  logic [NUM_CH-1:0] evt_c, ovf_set_c, ovf_clr_c;
  logic [31:0]       reg_c, shaped_c;

  // Address decode: 33-bit compare so a window at the top of the map cannot wrap
  assign addr_ext_c = {1'b0, bus.addr};
  assign bus.sel    = (addr_ext_c >= {1'b0, BASE}) &&
                      (addr_ext_c <  ({1'b0, BASE} + 33'(WIN_SZ)));
  assign wi_c       = 6'((bus.addr - BASE) >> 2);
  assign acc_c      = bus.req && bus.sel && (bus.size != 2'b00);
  assign wr_c       = acc_c && bus.rw && (bus.size == 2'b11);
  assign rd_c       = acc_c && !bus.rw;
  assign evt_c      = inc_i & en_q & {NUM_CH{glb_q}};
  assign ovf_clr_c  = (wr_c && (wi_c == WI_OVF)) ? bus.wdata[NUM_CH-1:0] : '0;

  // Register read mux and byte/half lane extraction
  always_comb begin
    reg_c = '0;
    if (wi_c == WI_CTRL)      reg_c = {glb_q, 31'(en_q)};
    else if (wi_c == WI_OVF)  reg_c = 32'(ovf_q);
    else if (wi_c == WI_MASK) reg_c = 32'(mask_q);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wi_c[5:4] == GRP_LIVE && wi_c[3:0] == 4'(i)) reg_c = 32'(cnt_q[i]);
      if (wi_c[5:4] == GRP_SNAP && wi_c[3:0] == 4'(i)) reg_c = 32'(snap_q[i]);
    end
    case (bus.size)
      2'b01:   shaped_c = 32'(8'(reg_c >> {bus.addr[1:0], 3'b000}));
      2'b10:   shaped_c = 32'(16'(reg_c >> {bus.addr[1], 4'b0000}));
      default: shaped_c = reg_c;
    endcase
  end

  // Next state: bus write beats increment, snapshot takes pre-increment value
  always_comb begin
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    ovf_set_c = '0;
    en_d      = en_q;
    glb_d     = glb_q;
    mask_d    = mask_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_c && wi_c[5:4] == GRP_LIVE && wi_c[3:0] == 4'(i)) begin
        cnt_d[i] = bus.wdata[CNT_W-1:0];
      end else begin
`ifdef PERFCNT_RD_CLEAR_EN
        if (rd_c && wi_c[5:4] == GRP_LIVE && wi_c[3:0] == 4'(i)) cnt_d[i] = '0;
`endif
        if (evt_c[i]) begin
          ovf_set_c[i] = &cnt_d[i];
          cnt_d[i]     = cnt_d[i] + CNT_W'(1);
        end
      end
      if (wr_c && wi_c == WI_SNAP) snap_d[i] = cnt_q[i];
    end
    if (wr_c && wi_c == WI_CTRL) begin
      en_d  = bus.wdata[NUM_CH-1:0];
      glb_d = bus.wdata[31];
    end
    if (wr_c && wi_c == WI_MASK) mask_d = bus.wdata[NUM_CH-1:0];
    ovf_d    = (ovf_q & ~ovf_clr_c) | ovf_set_c;
    rvalid_d = rd_c;
    rdata_d  = rd_c ? shaped_c : '0;
    irq_d    = |(ovf_q & mask_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      en_q     <= '0;
      glb_q    <= 1'b0;
      ovf_q    <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      en_q     <= en_d;
      glb_q    <= glb_d;
      ovf_q    <= ovf_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: directed vector table, random traffic against a behavioural model.
module tb_perf_counter_bank;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned NCH  = 4;
`ifdef PERFCNT_RD_CLEAR_EN
  localparam bit RDC = 1'b1;
`else
  localparam bit RDC = 1'b0;
`endif

  typedef struct {
    logic        rq;
    logic [31:0] off;
    logic        rw;
    logic [1:0]  sz;
    logic [31:0] wd;
    logic [3:0]  ic;
    logic [31:0] erd;
    logic        erv;
    logic        cirq;
    logic        eirq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] inc;
  logic       irq;
  perf_bus_if bus ();

  perf_counter_bank #(.BASE(BASE), .NUM_CH(NCH), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .inc_i(inc), .irq_o(irq)
  );

  always #5 clk = ~clk;

  logic [31:0] m_cnt  [NCH];
  logic [31:0] m_snap [NCH];
  logic [3:0]  m_en, m_ovf, m_mask;
  logic        m_glb;
  int          n_pass = 0;
  int          n_tot  = 0;
  vec_t        tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'h100);
  endfunction

  function automatic logic [31:0] m_reg(input logic [31:0] a);
    logic [31:0] ow;
    ow = (a - BASE) & ~32'h3;
    if (ow == 32'h0) return {m_glb, 27'd0, m_en};
    if (ow == 32'h4) return {28'd0, m_ovf};
    if (ow == 32'h8) return {28'd0, m_mask};
    for (int i = 0; i < NCH; i++) begin
      if (ow == 32'(32'h40 + 4 * i)) return m_cnt[i];
      if (ow == 32'(32'h80 + 4 * i)) return m_snap[i];
    end
    return 32'h0;
  endfunction

  function automatic logic [31:0] shape(input logic [31:0] v, input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b01) return (v >> (8 * a[1:0])) & 32'hFF;
    if (sz == 2'b10) return (v >> (16 * a[1])) & 32'hFFFF;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]  = 32'h0;
      m_snap[i] = 32'h0;
    end
    m_en = 4'h0; m_ovf = 4'h0; m_mask = 4'h0; m_glb = 1'b0;
  endtask

  // One bus cycle: drive at negedge, sample after posedge, check and advance the model
  task automatic cycle(input logic rq, input logic [31:0] a, input logic w, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [3:0] ic,
                       output logic [31:0] ard, output logic arv, output logic airq);
    logic        acc, wr, rd, erv, eirq, carry;
    logic [31:0] ow, erd, v;
    logic [31:0] n_cnt [NCH];
    logic [3:0]  set;
    @(negedge clk);
    bus.req = rq; bus.addr = a; bus.rw = w; bus.size = sz; bus.wdata = wd; inc = ic;
    #1 chk("sel", 32'(bus.sel), 32'(in_win(a)));
    acc  = rq && in_win(a) && (sz != 2'b00);
    wr   = acc && w && (sz == 2'b11);
    rd   = acc && !w;
    ow   = (a - BASE) & ~32'h3;
    erv  = rd;
    erd  = rd ? shape(m_reg(a), a, sz) : 32'h0;
    eirq = |(m_ovf & m_mask);
    @(posedge clk);
    #1;
    ard = bus.rdata; arv = bus.rvalid; airq = irq;
    chk("model rdata", ard, erd);
    chk("model rvalid", 32'(arv), 32'(erv));
    chk("model irq", 32'(airq), 32'(eirq));
    set = 4'h0;
    for (int i = 0; i < NCH; i++) begin
      if (wr && ow == 32'(32'h40 + 4 * i)) begin
        n_cnt[i] = wd;
      end else begin
        v = m_cnt[i];
        if (RDC && rd && ow == 32'(32'h40 + 4 * i)) v = 32'h0;
        if (ic[i] && m_glb && m_en[i]) begin
          {carry, v} = {1'b0, v} + 33'd1;
          set[i] = carry;
        end
        n_cnt[i] = v;
      end
    end
    if (wr && ow == 32'hC) for (int i = 0; i < NCH; i++) m_snap[i] = m_cnt[i];
    m_ovf = (m_ovf & ~((wr && ow == 32'h4) ? wd[3:0] : 4'h0)) | set;
    if (wr && ow == 32'h0) begin m_en = wd[3:0]; m_glb = wd[31]; end
    if (wr && ow == 32'h8) m_mask = wd[3:0];
    for (int i = 0; i < NCH; i++) m_cnt[i] = n_cnt[i];
  endtask

  function automatic vec_t mk(input logic rq, input logic [31:0] off, input logic rw, input logic [1:0] sz,
                              input logic [31:0] wd, input logic [3:0] ic, input logic [31:0] erd, input logic erv);
    vec_t v;
    v.rq = rq; v.off = off; v.rw = rw; v.sz = sz; v.wd = wd; v.ic = ic;
    v.erd = erd; v.erv = erv; v.cirq = 1'b0; v.eirq = 1'b0;
    return v;
  endfunction

  function automatic vec_t vw(input logic [31:0] off, input logic [31:0] d,
                              input logic [3:0] ic = 4'h0, input logic [1:0] sz = 2'b11);
    return mk(1'b1, off, 1'b1, sz, d, ic, 32'h0, 1'b0);
  endfunction

  function automatic vec_t vr(input logic [31:0] off, input logic [31:0] e,
                              input logic [1:0] sz = 2'b11, input logic [3:0] ic = 4'h0);
    return mk(1'b1, off, 1'b0, sz, 32'h0, ic, e, 1'b1);
  endfunction

  function automatic vec_t vi(input logic [3:0] ic);
    return mk(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, ic, 32'h0, 1'b0);
  endfunction

  function automatic vec_t virq(input vec_t v, input logic e);
    vec_t r;
    r = v; r.cirq = 1'b1; r.eirq = e;
    return r;
  endfunction

  initial begin
    logic [31:0] ard, a, wd;
    logic        arv, airq;
    logic [31:0] offs [15] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h40, 32'h44, 32'h48, 32'h4C,
                               32'h50, 32'h80, 32'h84, 32'h8C, 32'h90, 32'h20, 32'hFC};
    bus.req = 1'b0; bus.addr = 32'h0; bus.rw = 1'b0; bus.size = 2'b00; bus.wdata = 32'h0;
    inc = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset rvalid", 32'(bus.rvalid), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Reset values
    tbl.push_back(virq(vr(32'h00, 32'h0), 1'b0));
    tbl.push_back(vr(32'h04, 32'h0));
    tbl.push_back(vr(32'h40, 32'h0));
    tbl.push_back(vr(32'h80, 32'h0));
    // Enables and global gate
    tbl.push_back(vw(32'h00, 32'h8000_0001));
    for (int i = 0; i < 10; i++) tbl.push_back(vi(4'b0001));
    for (int i = 0; i < 10; i++) tbl.push_back(vi(4'b0010));
    tbl.push_back(vr(32'h40, 32'd10));
    tbl.push_back(vr(32'h44, 32'd0));
    tbl.push_back(vw(32'h00, 32'h0000_0001));
    for (int i = 0; i < 5; i++) tbl.push_back(vi(4'b0001));
    tbl.push_back(vr(32'h40, RDC ? 32'd0 : 32'd10));
    // Wrap, overflow, irq, W1C
    tbl.push_back(vw(32'h40, 32'hFFFF_FFFE));
    tbl.push_back(vw(32'h00, 32'h8000_0001));
    for (int i = 0; i < 3; i++) tbl.push_back(vi(4'b0001));
    tbl.push_back(virq(vw(32'h08, 32'h1), 1'b0));
    tbl.push_back(virq(vr(32'h40, 32'd1), 1'b1));
    tbl.push_back(virq(vr(32'h04, 32'h1), 1'b1));
    tbl.push_back(virq(vw(32'h04, 32'h1), 1'b1));
    tbl.push_back(virq(vr(32'h04, 32'h0), 1'b0));
    tbl.push_back(virq(vw(32'h40, 32'hFFFF_FFFF), 1'b0));
    tbl.push_back(virq(vw(32'h04, 32'h1, 4'b0001), 1'b0));
    tbl.push_back(virq(vr(32'h04, 32'h1), 1'b1));
    tbl.push_back(vr(32'h40, 32'h0));
    tbl.push_back(vw(32'h04, 32'h1));
    tbl.push_back(vr(32'h04, 32'h0));
    tbl.push_back(vw(32'h08, 32'h0));
    // Snapshot with concurrent increment, sub-word reads
    tbl.push_back(vw(32'h40, 32'h1234_5678));
    tbl.push_back(vw(32'h0C, 32'hDEAD_BEEF, 4'b0001));
    tbl.push_back(vr(32'h80, 32'h1234_5678));
    tbl.push_back(vr(32'h82, 32'h34, 2'b01));
    tbl.push_back(vr(32'h82, 32'h1234, 2'b10));
    tbl.push_back(vr(32'h0C, 32'h0));
    tbl.push_back(vr(32'h40, 32'h1234_5679));
    // Ignored accesses
    tbl.push_back(vw(32'h40, 32'h0, 4'h0, 2'b01));
    tbl.push_back(vr(32'h40, RDC ? 32'h0 : 32'h1234_5679));
    tbl.push_back(vw(32'h50, 32'h5));
    tbl.push_back(vr(32'h50, 32'h0));
    tbl.push_back(mk(1'b1, 32'h40, 1'b0, 2'b00, 32'h0, 4'h0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h100, 1'b0, 2'b11, 32'h0, 4'h0, 32'h0, 1'b0));
    // Read concurrent with increment
    tbl.push_back(vw(32'h40, 32'd7));
    tbl.push_back(vr(32'h40, 32'd7, 2'b11, 4'b0001));
    tbl.push_back(vr(32'h40, RDC ? 32'd1 : 32'd8));

    foreach (tbl[k]) begin
      cycle(tbl[k].rq, BASE + tbl[k].off, tbl[k].rw, tbl[k].sz, tbl[k].wd, tbl[k].ic, ard, arv, airq);
      chk($sformatf("vec%0d rdata", k), ard, tbl[k].erd);
      chk($sformatf("vec%0d rvalid", k), 32'(arv), 32'(tbl[k].erv));
      if (tbl[k].cirq) chk($sformatf("vec%0d irq", k), 32'(airq), 32'(tbl[k].eirq));
    end

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      a = BASE + offs[$urandom_range(0, 14)] + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 1) ? BASE + 32'h100 + 32'($urandom_range(0, 64)) : BASE - 32'd4;
      wd = $urandom;
      if (((a - BASE) & 32'hC0) == 32'h40 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            wd, 4'($urandom_range(0, 15)), ard, arv, airq);
    end

    // Reset in the middle of a read aborts it
    @(negedge clk);
    bus.req = 1'b1; bus.addr = BASE + 32'h40; bus.rw = 1'b0; bus.size = 2'b11; inc = 4'h0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort rvalid", 32'(bus.rvalid), 32'h0);
    chk("abort rdata", bus.rdata, 32'h0);
    @(negedge clk);
    bus.req = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("abort no late rvalid", 32'(bus.rvalid), 32'h0);
    cycle(1'b1, BASE + 32'h00, 1'b0, 2'b11, 32'h0, 4'h0, ard, arv, airq);
    chk("post reset ctrl", ard, 32'h0);
    cycle(1'b1, BASE + 32'h48, 1'b0, 2'b11, 32'h0, 4'h0, ard, arv, airq);
    chk("post reset cnt2", ard, 32'h0);

    @(negedge clk);
    bus.req = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
